// File: rtl/pulsador_debounce_if.sv
// Button-side bundle of the debouncer: raw buttons in, clean levels, strobes and
// the lowest-pressed-note encoder out.
interface pulsador_debounce_if #(
    parameter int NumBtn = 7
);
    localparam int IdxW = (NumBtn > 1) ? $clog2(NumBtn) : 1;

    logic [NumBtn-1:0] pulsadorIn;
    logic [NumBtn-1:0] pulsadorOut;
    logic [NumBtn-1:0] pressPulse;
    logic [NumBtn-1:0] releasePulse;
    logic              noteValid;
    logic [IdxW-1:0]   noteIdx;

    modport master (
        output pulsadorIn,
        input  pulsadorOut,
        input  pressPulse,
        input  releasePulse,
        input  noteValid,
        input  noteIdx
    );

    modport slave (
        input  pulsadorIn,
        output pulsadorOut,
        output pressPulse,
        output releasePulse,
        output noteValid,
        output noteIdx
    );
endinterface

// File: rtl/pulsador_debounce.sv
// Per-channel synchronise + debounce of active-low push-buttons, with registered
// press/release strobes and a lowest-index pressed-note encoder.
module pulsador_debounce #(
    parameter int NumBtn         = 7,
    parameter int DebounceCycles = 250
) (
    input  logic                 clockIn,
    input  logic                 resetN,
    pulsador_debounce_if.slave   bus
);
    localparam int CntW = $clog2(DebounceCycles);
    localparam int IdxW = (NumBtn > 1) ? $clog2(NumBtn) : 1;

    localparam logic [CntW-1:0] CNT_ZERO = {CntW{1'b0}};
    localparam logic [CntW-1:0] CNT_ONE  = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] CNT_LAST = CntW'(DebounceCycles - 1);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DN      = 2'd2,
        ST_WAIT_UP = 2'd3
    } state_t;

    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;

    state_t            state_q [NumBtn];
    state_t            state_d [NumBtn];
    logic [CntW-1:0]   cnt_q   [NumBtn];
    logic [CntW-1:0]   cnt_d   [NumBtn];

    logic [NumBtn-1:0] out_q;
    logic [NumBtn-1:0] out_d;
    logic [NumBtn-1:0] press_q;
    logic [NumBtn-1:0] press_d;
    logic [NumBtn-1:0] release_q;
    logic [NumBtn-1:0] release_d;

    logic              note_valid_q;
    logic              note_valid_d;
    logic [IdxW-1:0]   note_idx_q;
    logic [IdxW-1:0]   note_idx_d;

    // Two-flop synchroniser; idles high so a held button re-debounces after reset.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= {NumBtn{1'b1}};
            sync2_q <= {NumBtn{1'b1}};
        end else begin
            sync1_q <= bus.pulsadorIn;
            sync2_q <= sync1_q;
        end
    end

    // State register: FSM state, hold counters and registered level/strobes.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NumBtn; i++) begin
                state_q[i] <= ST_UP;
                cnt_q[i]   <= CNT_ZERO;
            end
            out_q     <= {NumBtn{1'b1}};
            press_q   <= {NumBtn{1'b0}};
            release_q <= {NumBtn{1'b0}};
        end else begin
            for (int i = 0; i < NumBtn; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state logic: any disagreeing sample during a wait aborts back to the stable state.
    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_UP: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_WAIT_DN;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_WAIT_DN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_UP;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_DN;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_DN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_WAIT_UP;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_WAIT_UP: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_DN;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_UP;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_UP;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output logic: level flips and strobes fire only on a completed wait.
    always_comb begin
        out_d     = out_q;
        press_d   = {NumBtn{1'b0}};
        release_d = {NumBtn{1'b0}};
        for (int i = 0; i < NumBtn; i++) begin
            if ((state_q[i] == ST_WAIT_DN) && (state_d[i] == ST_DN)) begin
                out_d[i]   = 1'b0;
                press_d[i] = 1'b1;
            end else if ((state_q[i] == ST_WAIT_UP) && (state_d[i] == ST_UP)) begin
                out_d[i]     = 1'b1;
                release_d[i] = 1'b1;
            end else begin
                out_d[i] = out_q[i];
            end
        end
    end

    // Encoder input: scan high-to-low so the lowest pressed index wins.
    always_comb begin
        note_valid_d = ~(&out_q);
        note_idx_d   = {IdxW{1'b0}};
        for (int i = NumBtn - 1; i >= 0; i--) begin
            note_idx_d = out_q[i] ? note_idx_d : IdxW'(i);
        end
    end

    // Encoder register, one cycle behind the debounced level.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            note_valid_q <= 1'b0;
            note_idx_q   <= {IdxW{1'b0}};
        end else begin
            note_valid_q <= note_valid_d;
            note_idx_q   <= note_idx_d;
        end
    end

    assign bus.pulsadorOut  = out_q;
    assign bus.pressPulse   = press_q;
    assign bus.releasePulse = release_q;
    assign bus.noteValid    = note_valid_q;
    assign bus.noteIdx      = note_idx_q;
endmodule

// File: tb/tb_pulsador_debounce.sv
// Randomised and directed bench for pulsador_debounce against a sliding-window model.
module tb_pulsador_debounce;
    localparam int NB = 4;
    localparam int DC = 4;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulsador_debounce_if #(.NumBtn(NB)) bus ();

    pulsador_debounce #(.NumBtn(NB), .DebounceCycles(DC)) dut (
        .clockIn (clk),
        .resetN  (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: raw samples per edge, newest first; the FSM acts on the sample two edges old.
    logic [NB-1:0] hist [$];
    logic [NB-1:0] exp_out;
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_rel;
    logic          exp_valid;
    logic [IW-1:0] exp_idx;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < DC + 2; k++) hist.push_back(4'b1111);
        exp_out   = 4'b1111;
        exp_press = 4'b0000;
        exp_rel   = 4'b0000;
        exp_valid = 1'b0;
        exp_idx   = 2'd0;
    endtask

    // A level flips once the last DC visible samples all disagree with it.
    task automatic tick();
        bit agree;
        @(posedge clk);
        if (rst_n) begin
            hist.push_front(bus.pulsadorIn);
            void'(hist.pop_back());
            exp_valid = (exp_out != 4'b1111);
            exp_idx   = 2'd0;
            for (int i = NB - 1; i >= 0; i--) if (!exp_out[i]) exp_idx = IW'(i);
            exp_press = 4'b0000;
            exp_rel   = 4'b0000;
            for (int ch = 0; ch < NB; ch++) begin
                agree = 1'b1;
                for (int k = 2; k < DC + 2; k++) if (hist[k][ch] == exp_out[ch]) agree = 1'b0;
                if (agree) begin
                    if (exp_out[ch]) exp_press[ch] = 1'b1;
                    else             exp_rel[ch]   = 1'b1;
                    exp_out[ch] = ~exp_out[ch];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pulsadorIn = 4'b1111;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b/%b/%0d want 1111/0000/0000/0/0",
                     bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", c,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
        end
    endtask

    task automatic test_clean_press();
        int lat = -1;
        int presses = 0;
        int rels = 0;
        bus.pulsadorIn = 4'b1110;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL clean_press cyc %0d: got %b want %b", c,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
            if (bus.pressPulse != 4'b0000) presses++;
            if (lat >= 0 && c == lat + 1) begin
                checks++;
                if (bus.noteValid !== 1'b1 || bus.noteIdx !== 2'd0) begin
                    errors++;
                    $display("FAIL clean_press_encoder: got valid=%b idx=%0d want valid=1 idx=0", bus.noteValid, bus.noteIdx);
                end
            end
            if (lat < 0 && bus.pulsadorOut[0] == 1'b0) lat = c;
        end
        checks++;
        if (lat != DC + 1) begin
            errors++;
            $display("FAIL clean_press_latency: got %0d edges want %0d", lat, DC + 1);
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL clean_press_strobes: got %0d want 1", presses);
        end
        bus.pulsadorIn = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.releasePulse == 4'b0001) rels++;
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL clean_release cyc %0d: got %b want %b", c,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
        end
        checks++;
        if (rels != 1) begin
            errors++;
            $display("FAIL clean_release_strobes: got %0d want 1", rels);
        end
    endtask

    task automatic test_bounce();
        logic pat [15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int presses = 0;
        int rels = 0;
        int press_at = -1;
        for (int c = 0; c < 15; c++) begin
            bus.pulsadorIn = {1'b1, pat[c], 2'b11};
            tick();
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %b want %b", c,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
            if (bus.pressPulse[2]) begin presses++; press_at = c; end
            if (bus.releasePulse[2]) rels++;
        end
        checks++;
        if (presses != 1 || rels != 0 || press_at != 5 + DC + 1) begin
            errors++;
            $display("FAIL bounce_strobes: got press=%0d at %0d release=%0d want press=1 at %0d release=0",
                     presses, press_at, rels, 5 + DC + 1);
        end
        bus.pulsadorIn = 4'b1111;
        repeat (10) tick();
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 12; c++) begin
            bus.pulsadorIn = (c < 3) ? 4'b1101 : 4'b1111;
            tick();
            checks++;
            if (bus.pulsadorOut !== 4'b1111 || bus.pressPulse !== 4'b0000 || bus.releasePulse !== 4'b0000 ||
                exp_out !== 4'b1111) begin
                errors++;
                $display("FAIL glitch cyc %0d: got out=%b press=%b rel=%b want 1111/0000/0000",
                         c, bus.pulsadorOut, bus.pressPulse, bus.releasePulse);
            end
        end
    endtask

    task automatic test_pair();
        int pairs = 0;
        int rels = 0;
        bus.pulsadorIn = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.pressPulse == 4'b1010) pairs++;
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL pair_press cyc %0d: got %b want %b", c,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
        end
        checks++;
        if (pairs != 1 || bus.noteIdx !== 2'd1 || bus.noteValid !== 1'b1) begin
            errors++;
            $display("FAIL pair_same_cycle: got pairs=%0d idx=%0d valid=%b want 1/1/1", pairs, bus.noteIdx, bus.noteValid);
        end
        bus.pulsadorIn = 4'b0111;
        repeat (10) tick();
        checks++;
        if (bus.noteIdx !== 2'd3 || bus.noteValid !== 1'b1) begin
            errors++;
            $display("FAIL pair_release1: got idx=%0d valid=%b want 3/1", bus.noteIdx, bus.noteValid);
        end
        bus.pulsadorIn = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.releasePulse == 4'b1000) rels++;
        end
        checks++;
        if (rels != 1 || bus.noteValid !== 1'b0 || bus.pulsadorOut !== 4'b1111) begin
            errors++;
            $display("FAIL pair_release3: got rels=%0d valid=%b out=%b want 1/0/1111", rels, bus.noteValid, bus.pulsadorOut);
        end
    endtask

    task automatic test_reset_mid();
        int press_at = -1;
        bus.pulsadorIn = 4'b0111;
        repeat (10) tick();
        bus.pulsadorIn = 4'b0110;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid_async: got %b/%b/%b/%b/%0d want 1111/0000/0000/0/0",
                     bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.pressPulse[0] && press_at < 0) press_at = c;
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", c,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
        end
        checks++;
        if (press_at != DC + 1) begin
            errors++;
            $display("FAIL reset_mid_redebounce: got press at edge %0d want %0d", press_at, DC + 1);
        end
        bus.pulsadorIn = 4'b1111;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int hold [NB];
        logic [NB-1:0] lvl = 4'b1111;
        for (int ch = 0; ch < NB; ch++) hold[ch] = 1;
        for (int c = 0; c < 800; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                hold[ch]--;
                if (hold[ch] == 0) begin
                    lvl[ch]  = ~lvl[ch];
                    hold[ch] = int'($urandom_range(1, 2 * DC + 2));
                end
            end
            bus.pulsadorIn = lvl;
            tick();
            checks++;
            if ({bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx} !== {exp_out, exp_press, exp_rel, exp_valid, exp_idx}) begin
                errors++;
                $display("FAIL random cyc %0d in=%b: got %b want %b", c, lvl,
                         {bus.pulsadorOut, bus.pressPulse, bus.releasePulse, bus.noteValid, bus.noteIdx},
                         {exp_out, exp_press, exp_rel, exp_valid, exp_idx});
            end
        end
    endtask

    initial begin
        bus.pulsadorIn = 4'b1111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_pair();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
